mdio_responder: RTL and testbench
=================================

# mdio_responder

Clause-22 MDIO management-frame responder: the PHY-side counterpart to the station-management controller that drives the `eN_mdc`/`eN_mdio` pins. It oversamples MDC/MDIO in the system clock domain, decodes read and write frames addressed to its PHY address, and bridges them to a 32×16 register port. It serves two roles: as an emulated PHY management slave in loopback/bring-up builds, and as the bus-functional responder in the PHY-controller testbench.

## Interface
- `PHY_ADDR`, default 5'd1: PHYAD this instance answers to; no broadcast address.
- `PREAMBLE_LEN`, default 32: consecutive 1s required before ST. Legal range 1..32.
- `SYNC_STAGES`, default 2: synchronizer depth on `mdc_i`/`mdio_i`. Minimum 2.
- `clk  in  1`: system clock. Must be ≥ 8× MDC frequency.
- `rst_n  in  1`: asynchronous, active-low reset.
- `mdc_i  in  1`: MDC from station manager. Asynchronous to `clk`.
- `mdio_i  in  1`: MDIO pad input. Asynchronous to `clk`.
- `mdio_o  out  1`: MDIO output value.
- `mdio_oe  out  1`: MDIO output enable. 1 = drive `mdio_o`.
- `reg_addr  out  5`: REGAD of the current access.
- `reg_rd  out  1`: one-clk read strobe.
- `reg_rdata  in  16`: read data. Must be valid on the clk after `reg_rd`.
- `reg_wr  out  1`: one-clk write strobe.
- `reg_wdata  out  16`: write data. Valid while `reg_wr` is high.
- `frame_err  out  1`: one-clk pulse on a malformed frame.

## Operation
- `mdc_i` and `mdio_i` each pass through a `SYNC_STAGES` flop chain. One extra flop on MDC detects its rising edge (`mdc_rise`).
- On each `mdc_rise`, the synchronized MDIO value is the sampled bit. All FSM actions occur only on `mdc_rise` cycles.
- FSM states: PRE, ST, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA, SKIP.
- PRE
  - Counter `pcnt` increments on sampled 1 and saturates at `PREAMBLE_LEN`. A sampled 0 with `pcnt` < `PREAMBLE_LEN` clears `pcnt`.
  - A sampled 0 with `pcnt` == `PREAMBLE_LEN` is ST bit 0 → ST.
- ST: expects 1. A sampled 0 → `frame_err` pulse, go to PRE with `pcnt`=0.
- OP: 2 bits, MSB first. 10 = read, 01 = write. 00 or 11 (Clause-45 style) → `frame_err`, go to SKIP.
- PHYAD: 5 bits, MSB first. Mismatch with `PHY_ADDR` → SKIP; no error, no bus drive.
- REGAD: 5 bits, MSB first, loaded into `reg_addr`.
  - On read: the clk after the 5th bit, `reg_rd` pulses. On the following clk, `reg_rdata` is captured into a 16-bit shift register.
- TA (read)
  - First TA bit time: `mdio_oe`=0.
  - On the `mdc_rise` that ends TA bit 1: assert `mdio_oe`=1 with `mdio_o`=0.
  - Go to RD_DATA.
- RD_DATA
  - On each subsequent `mdc_rise`, `mdio_o` shifts out D15..D0.
  - On the `mdc_rise` after D0 has been presented: `mdio_oe`=0, `mdio_o`=1, go to PRE with `pcnt`=0.
- TA (write)
  - Samples 2 bits, expecting 1 then 0. Any mismatch → `frame_err`, go to SKIP.
- WR_DATA
  - Samples 16 bits MSB-first into `reg_wdata`.
  - The clk after the 16th bit, `reg_wr` pulses. Then go to PRE with `pcnt`=0.
- SKIP
  - Counts the remaining bits of a 32-bit post-preamble frame (ST through data), then → PRE with `pcnt`=0. Bus is never driven.
  - `frame_err` itself does not change this count.
- Idle/preamble bits in PRE are never driven; `mdio_oe` is 1 only from TA bit 2 through D0 of an addressed read.

## Timing
- Reset values: `mdio_oe`=0, `mdio_o`=1, `reg_addr`=0, `reg_rd`=0, `reg_wr`=0, `reg_wdata`=0, `frame_err`=0. FSM in PRE, `pcnt`=0, shift registers 0.
- `rst_n` assertion mid-frame releases MDIO asynchronously. After deassertion, the block waits for a full preamble.
- `mdc_rise` lags the MDC pin edge by `SYNC_STAGES`+1 clk. `mdio_o`/`mdio_oe` are registered and change 1 clk after `mdc_rise`.
  - MDC edge → pad change is ≤ `SYNC_STAGES`+2 clk: 40 ns at 100 MHz with defaults, inside the 0–300 ns Clause-22 window.
- Sample alignment: MDIO is sampled through the same sync depth as MDC, so it reflects the pin value at the MDC edge.
- `reg_rd` to `reg_rdata` capture is exactly 1 clk. Both occur well before the TA bit-2 edge, given `clk` ≥ 8× MDC.
- A write becomes visible on the register port 1 clk after the `mdc_rise` that samples D0.
- No MDC timeout: a stalled MDC freezes the FSM with outputs held.

## Test plan
- Write: 32×1 preamble, ST=01, OP=01, PHYAD=1, REGAD=5'h04, TA=10, data 16'hA5C3 → exactly one `reg_wr` pulse, `reg_addr`=4, `reg_wdata`=16'hA5C3. `mdio_oe` stays 0 throughout.
- Read: preamble, OP=10, PHYAD=1, REGAD=5'h02, `reg_rdata`=16'h1234 → one `reg_rd` pulse with `reg_addr`=2. `mdio_oe` rises after the TA1 edge. STA samples 0 then 0x1234 MSB-first on 17 consecutive edges, then `mdio_oe`=0.
- Wrong PHYAD=5'd3 read → no `reg_rd`, no `frame_err`, `mdio_oe` never 1. A following correct frame with a 32-bit preamble is serviced.
- Short preamble: 31 ones, then a valid write to PHYAD 1 → ignored, no `reg_wr`. A subsequent 32-one frame succeeds.
- OP=11, then a valid write to PHYAD 1 → one `frame_err` pulse, and 32 bits are skipped without driving. The next valid write succeeds.
- `rst_n` low during RD_DATA bit D8 → `mdio_oe`=0 within the reset assertion, all outputs at reset values. No response until a new full preamble.

Source files
------------

// File: rtl/mdio_responder.sv
// Clause-22 MDIO management-frame responder (PHY side).
// Oversamples MDC/MDIO in the clk domain, decodes read/write frames addressed
// to PHY_ADDR and bridges them to a 32x16 register port.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_LEN = 32,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr,
  output logic [15:0] reg_wdata,
  output logic        frame_err
);

  localparam logic [3:0] S_PRE  = 4'd0;
  localparam logic [3:0] S_ST   = 4'd1;
  localparam logic [3:0] S_OP   = 4'd2;
  localparam logic [3:0] S_PHY  = 4'd3;
  localparam logic [3:0] S_REG  = 4'd4;
  localparam logic [3:0] S_TA   = 4'd5;
  localparam logic [3:0] S_RD   = 4'd6;
  localparam logic [3:0] S_WR   = 4'd7;
  localparam logic [3:0] S_SKIP = 4'd8;

  localparam logic [5:0] PLEN = 6'(PREAMBLE_LEN);

  logic [SYNC_STAGES-1:0] mdc_sync, mdio_sync;
  logic                   mdc_d;
  logic                   mdc_rise, sbit;

  logic [3:0]  state;
  logic [5:0]  pcnt;     // consecutive preamble ones, saturating at PLEN
  logic [5:0]  fcnt;     // post-preamble bits sampled so far (ST bit 0 = 1)
  logic [4:0]  bcnt;     // bit index inside the current field
  logic [1:0]  op;
  logic [4:0]  phy_sh;
  logic        is_rd;
  logic        rd_cap;   // one clk after reg_rd: reg_rdata is valid
  logic [15:0] shreg;

  // Both pins go through the same depth so MDIO is sampled as it was at the MDC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_sync  <= '0;
      mdio_sync <= '1;
      mdc_d     <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc_i};
      mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
      mdc_d     <= mdc_sync[SYNC_STAGES-1];
    end
  end

  assign mdc_rise = mdc_sync[SYNC_STAGES-1] & ~mdc_d;
  assign sbit     = mdio_sync[SYNC_STAGES-1];

  // Frame decoder; every FSM action is qualified by mdc_rise, so a stalled MDC holds all state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PRE;
      pcnt      <= '0;
      fcnt      <= '0;
      bcnt      <= '0;
      op        <= '0;
      phy_sh    <= '0;
      is_rd     <= 1'b0;
      rd_cap    <= 1'b0;
      shreg     <= '0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      reg_addr  <= '0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_wdata <= '0;
      frame_err <= 1'b0;
    end else begin
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      frame_err <= 1'b0;
      rd_cap    <= reg_rd;
      if (rd_cap) shreg <= reg_rdata;
      if (mdc_rise) begin
        if (state != S_PRE) fcnt <= fcnt + 6'd1;
        case (state)
          S_PRE: begin
            if (sbit) begin
              if (pcnt < PLEN) pcnt <= pcnt + 6'd1;
            end else if (pcnt == PLEN) begin
              state <= S_ST;
              fcnt  <= 6'd1;
            end else begin
              pcnt <= '0;
            end
          end
          S_ST: begin
            if (sbit) begin
              state <= S_OP;
              bcnt  <= '0;
            end else begin
              frame_err <= 1'b1;
              state     <= S_PRE;
              pcnt      <= '0;
            end
          end
          S_OP: begin
            op <= {op[0], sbit};
            if (bcnt == 5'd1) begin
              bcnt <= '0;
              case ({op[0], sbit})
                2'b10:   begin is_rd <= 1'b1; state <= S_PHY; end
                2'b01:   begin is_rd <= 1'b0; state <= S_PHY; end
                default: begin frame_err <= 1'b1; state <= S_SKIP; end
              endcase
            end else begin
              bcnt <= bcnt + 5'd1;
            end
          end
          S_PHY: begin
            phy_sh <= {phy_sh[3:0], sbit};
            if (bcnt == 5'd4) begin
              bcnt  <= '0;
              state <= ({phy_sh[3:0], sbit} == PHY_ADDR) ? S_REG : S_SKIP;
            end else begin
              bcnt <= bcnt + 5'd1;
            end
          end
          S_REG: begin
            reg_addr <= {reg_addr[3:0], sbit};
            if (bcnt == 5'd4) begin
              bcnt   <= '0;
              reg_rd <= is_rd;
              state  <= S_TA;
            end else begin
              bcnt <= bcnt + 5'd1;
            end
          end
          S_TA: begin
            if (is_rd) begin
              // Drive the TA 0 from the end of TA bit 1 so the STA samples it on TA bit 2.
              mdio_oe <= 1'b1;
              mdio_o  <= 1'b0;
              bcnt    <= '0;
              state   <= S_RD;
            end else if (bcnt == 5'd0) begin
              if (sbit) bcnt <= 5'd1;
              else begin frame_err <= 1'b1; state <= S_SKIP; end
            end else begin
              bcnt <= '0;
              if (!sbit) state <= S_WR;
              else begin frame_err <= 1'b1; state <= S_SKIP; end
            end
          end
          S_RD: begin
            if (bcnt == 5'd16) begin
              mdio_oe <= 1'b0;
              mdio_o  <= 1'b1;
              state   <= S_PRE;
              pcnt    <= '0;
            end else begin
              mdio_o <= shreg[15];
              shreg  <= {shreg[14:0], 1'b0};
              bcnt   <= bcnt + 5'd1;
            end
          end
          S_WR: begin
            reg_wdata <= {reg_wdata[14:0], sbit};
            if (bcnt == 5'd15) begin
              reg_wr <= 1'b1;
              state  <= S_PRE;
              pcnt   <= '0;
            end else begin
              bcnt <= bcnt + 5'd1;
            end
          end
          S_SKIP: begin
            // Bit 32 of the post-preamble frame ends the skip.
            if (fcnt == 6'd31) begin
              state <= S_PRE;
              pcnt  <= '0;
            end
          end
          default: begin
            state <= S_PRE;
            pcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Directed frames for mdio_responder; a frame-level model predicts pulses and
// the bus-drive window, and a per-MDC-edge process checks the pad as the STA sees it.
module tb_mdio_responder;
  localparam int         PLEN = 32;
  localparam logic [4:0] PA   = 5'd1;

  logic        clk = 1'b0, rst_n = 1'b0, mdc_i = 1'b0, mdio_i = 1'b1;
  logic        mdio_o, mdio_oe, reg_rd, reg_wr, frame_err;
  logic [4:0]  reg_addr;
  logic [15:0] reg_rdata, reg_wdata;
  logic [15:0] mem [32];

  int n_tests = 0, n_fail = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
  logic [4:0]  w_addr = '0, r_addr = '0;
  logic [15:0] w_data = '0;
  logic        exp_oe = 1'b0, exp_o = 1'b1, chk_en = 1'b0;
  logic [15:0] rd_word = '0;

  mdio_responder #(.PHY_ADDR(PA), .PREAMBLE_LEN(PLEN), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .mdc_i(mdc_i), .mdio_i(mdio_i),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe), .reg_addr(reg_addr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_wr(reg_wr), .reg_wdata(reg_wdata), .frame_err(frame_err)
  );

  assign reg_rdata = mem[reg_addr];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pulse monitor: counts strobe cycles and latches the port values seen with them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr)    begin wr_cnt <= wr_cnt + 1; w_addr <= reg_addr; w_data <= reg_wdata; end
      if (reg_rd)    begin rd_cnt <= rd_cnt + 1; r_addr <= reg_addr; end
      if (frame_err) err_cnt <= err_cnt + 1;
    end
  end

  // Pad check at every MDC rising edge, where the STA samples.
  always @(posedge mdc_i) begin
    if (chk_en) begin
      chk("mdio_oe", {31'd0, mdio_oe}, {31'd0, exp_oe});
      if (exp_oe) begin
        chk("mdio_o", {31'd0, mdio_o}, {31'd0, exp_o});
        rd_word <= {rd_word[14:0], mdio_o};
      end
    end
  end

  task automatic send_bit(input logic v, input logic eo, input logic eov);
    mdc_i  = 1'b0;
    mdio_i = v;
    exp_oe = eo;
    exp_o  = eov;
    repeat (8) @(negedge clk);
    mdc_i = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [31:0] wbody(input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] d);
    return {2'b01, 2'b01, phy, rg, 2'b10, d};
  endfunction

  function automatic logic [31:0] rbody(input logic [4:0] phy, input logic [4:0] rg);
    return {2'b01, 2'b10, phy, rg, 2'b11, 16'hFFFF};
  endfunction

  // Sends pre ones then the 32-bit body; predicts the outcome from field values.
  task automatic run_frame(input string nm, input int pre, input logic [31:0] body, input int abort_at);
    logic [1:0] op, ta;
    logic [4:0] phy, rg;
    logic [15:0] dat, rdat;
    logic e_err, e_rd, e_wr, drv, eo, eov;
    int w0, r0, x0;
    op = body[29:28]; phy = body[27:23]; rg = body[22:18]; ta = body[17:16]; dat = body[15:0];
    rdat = mem[rg];
    e_err = 0; e_rd = 0; e_wr = 0;
    if (pre >= PLEN) begin
      if (body[31:30] != 2'b01) e_err = 1;
      else if (op == 2'b00 || op == 2'b11) e_err = 1;
      else if (phy != PA) ;
      else if (op == 2'b10) e_rd = 1;
      else if (ta != 2'b10) e_err = 1;
      else e_wr = 1;
    end
    drv = e_rd;
    w0 = wr_cnt; r0 = rd_cnt; x0 = err_cnt;
    for (int i = 0; i < pre; i++) send_bit(1'b1, 1'b0, 1'b1);
    for (int b = 0; b < 32; b++) begin
      if (b == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk({nm, " rst oe"}, {31'd0, mdio_oe}, 32'd0);
        chk({nm, " rst o"}, {31'd0, mdio_o}, 32'd1);
        chk({nm, " rst strobes"}, {29'd0, reg_rd, reg_wr, frame_err}, 32'd0);
        chk({nm, " rst addr"}, {27'd0, reg_addr}, 32'd0);
        chk({nm, " rst wdata"}, {16'd0, reg_wdata}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        break;
      end
      eo  = drv && (b >= 15);
      eov = (b == 15) ? 1'b0 : rdat[31-b];
      send_bit(body[31-b], eo, eov);
    end
    exp_oe = 1'b0;
    chk({nm, " wr cnt"},  wr_cnt - w0,  {31'd0, e_wr});
    chk({nm, " rd cnt"},  rd_cnt - r0,  {31'd0, e_rd});
    chk({nm, " err cnt"}, err_cnt - x0, {31'd0, e_err});
    if (e_wr) begin
      chk({nm, " wr addr"}, {27'd0, w_addr}, {27'd0, rg});
      chk({nm, " wr data"}, {16'd0, w_data}, {16'd0, dat});
    end
    if (e_rd) chk({nm, " rd addr"}, {27'd0, r_addr}, {27'd0, rg});
    if (drv && abort_at < 0) chk({nm, " rd word"}, {16'd0, rd_word}, {16'd0, rdat});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'(i * 257) ^ 16'h5A00;
    mem[2] = 16'h1234;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset oe", {31'd0, mdio_oe}, 32'd0);
    chk("reset o", {31'd0, mdio_o}, 32'd1);
    chk("reset strobes", {29'd0, reg_rd, reg_wr, frame_err}, 32'd0);
    chk("reset addr/wdata", {11'd0, reg_addr, reg_wdata}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_en = 1'b1;

    run_frame("write4", 32, wbody(PA, 5'h04, 16'hA5C3), -1);
    chk("write4 literal wdata", {16'd0, reg_wdata}, 32'h0000A5C3);
    chk("write4 literal addr", {27'd0, reg_addr}, 32'd4);

    run_frame("read2", 32, rbody(PA, 5'h02), -1);
    chk("read2 literal word", {16'd0, rd_word}, 32'h00001234);

    run_frame("wrong phyad", 32, rbody(5'd3, 5'h02), -1);
    run_frame("after wrong phyad", 32, wbody(PA, 5'h07, 16'h0F0F), -1);
    chk("after wrong phyad literal", {16'd0, w_data}, 32'h00000F0F);

    run_frame("short preamble", 31, wbody(PA, 5'h05, 16'hDEAD), -1);
    run_frame("after short", 32, wbody(PA, 5'h05, 16'hBEEF), -1);

    run_frame("op11", 32, {2'b01, 2'b11, PA, 5'h06, 2'b10, 16'h1111}, -1);
    run_frame("after op11", 40, wbody(PA, 5'h06, 16'h8001), -1);

    run_frame("st error", 32, {2'b00, 2'b10, PA, 5'h09, 2'b11, 16'hFFFF}, -1);
    run_frame("read9", 32, rbody(PA, 5'h09), -1);

    run_frame("bad ta", 32, {2'b01, 2'b01, PA, 5'h0A, 2'b11, 16'h7777}, -1);
    run_frame("write31", 32, wbody(PA, 5'h1F, 16'h0001), -1);

    run_frame("reset at D8", 32, rbody(PA, 5'h02), 23);
    run_frame("after reset short", 10, rbody(PA, 5'h02), -1);
    run_frame("after reset full", 32, rbody(PA, 5'h02), -1);
    chk("after reset literal word", {16'd0, rd_word}, 32'h00001234);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
